// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: in-system self-test sequencer for the two-input gate unit.
// Walks A/B through a Gray-ordered sweep and checks the seven gate outputs.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a_out,
    output logic        b_out,
    input  logic        and_in,
    input  logic        or_in,
    input  logic        not_in,
    input  logic        nand_in,
    input  logic        nor_in,
    input  logic        xor_in,
    input  logic        xnor_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [27:0] result
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        a_nx, b_nx;
    logic        pass_nx;
    logic [3:0]  mask_nx;
    logic [27:0] res_nx;
    logic [6:0]  got;
    logic [6:0]  expv;
    logic        miss;

    // Gray order: 00, 10, 11, 01 as {A,B}
    function automatic logic [1:0] vec(input logic [1:0] i);
        logic [1:0] v;
        case (i)
            2'd0:    v = 2'b00;
            2'd1:    v = 2'b10;
            2'd2:    v = 2'b11;
            default: v = 2'b01;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            result    <= 28'd0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            a_out     <= a_nx;
            b_out     <= b_nx;
            pass      <= pass_nx;
            fail_mask <= mask_nx;
            result    <= res_nx;
        end
    end

    always_comb begin
        got  = {and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in};
        expv = {a_out & b_out, a_out | b_out, ~a_out,
                ~(a_out & b_out), ~(a_out | b_out),
                a_out ^ b_out, ~(a_out ^ b_out)};
        // case inequality so X/Z from the unit is a mismatch
        miss = (got !== expv);

        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        a_nx     = a_out;
        b_nx     = b_out;
        pass_nx  = pass;
        mask_nx  = fail_mask;
        res_nx   = result;

        unique case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (start) begin
                    state_nx     = RUN;
                    idx_nx       = 2'd0;
                    cnt_nx       = 4'd0;
                    {a_nx, b_nx} = vec(2'd0);
                    pass_nx      = 1'b0;
                    mask_nx      = 4'd0;
                    res_nx       = 28'd0;
                end
            end
            RUN: begin
                if (cnt == SETTLE_C) begin
                    cnt_nx = 4'd0;
                    for (int k = 0; k < 4; k++) begin
                        if (idx == k[1:0]) begin
                            res_nx[7*k +: 7] = got;
                            if (miss) mask_nx[k] = 1'b1;
                        end
                    end
                    if (idx == 2'd3) begin
                        state_nx = FIN;
                        pass_nx  = (mask_nx == 4'd0);
                    end else begin
                        idx_nx       = idx + 2'd1;
                        {a_nx, b_nx} = vec(idx_nx);
                    end
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed bench for gate_sweep_ctrl.
// DUT 0 uses SETTLE=2 (with fault hook), DUT 1 SETTLE=0, DUT 2 SETTLE=15.
module tb_gate_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        st     [3];
    logic        a_o    [3];
    logic        b_o    [3];
    logic        g_and  [3];
    logic        g_or   [3];
    logic        g_not  [3];
    logic        g_nand [3];
    logic        g_nor  [3];
    logic        g_xor  [3];
    logic        g_xnor [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        pass_w [3];
    logic [3:0]  mask_w [3];
    logic [27:0] res_w  [3];
    logic [2:0]  xor_fault;

    int checks = 0;
    int errors = 0;

    localparam logic [27:0] GOLD  = 28'h758551D;
    localparam logic [27:0] FAULT = 28'h718541D;

    gate_sweep_ctrl #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(st[0]),
        .a_out(a_o[0]), .b_out(b_o[0]),
        .and_in(g_and[0]), .or_in(g_or[0]), .not_in(g_not[0]),
        .nand_in(g_nand[0]), .nor_in(g_nor[0]),
        .xor_in(g_xor[0]), .xnor_in(g_xnor[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_mask(mask_w[0]), .result(res_w[0])
    );

    gate_sweep_ctrl #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(st[1]),
        .a_out(a_o[1]), .b_out(b_o[1]),
        .and_in(g_and[1]), .or_in(g_or[1]), .not_in(g_not[1]),
        .nand_in(g_nand[1]), .nor_in(g_nor[1]),
        .xor_in(g_xor[1]), .xnor_in(g_xnor[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_mask(mask_w[1]), .result(res_w[1])
    );

    gate_sweep_ctrl #(.SETTLE(15)) u_s15 (
        .clk(clk), .rst(rst), .start(st[2]),
        .a_out(a_o[2]), .b_out(b_o[2]),
        .and_in(g_and[2]), .or_in(g_or[2]), .not_in(g_not[2]),
        .nand_in(g_nand[2]), .nor_in(g_nor[2]),
        .xor_in(g_xor[2]), .xnor_in(g_xnor[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_mask(mask_w[2]), .result(res_w[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_model
        assign g_and[g]  = a_o[g] & b_o[g];
        assign g_or[g]   = a_o[g] | b_o[g];
        assign g_not[g]  = ~a_o[g];
        assign g_nand[g] = ~(a_o[g] & b_o[g]);
        assign g_nor[g]  = ~(a_o[g] | b_o[g]);
        assign g_xor[g]  = xor_fault[g] ? 1'b0 : (a_o[g] ^ b_o[g]);
        assign g_xnor[g] = ~(a_o[g] ^ b_o[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ab_of(input int v);
        logic [1:0] t [4];
        t[0] = 2'b00;
        t[1] = 2'b10;
        t[2] = 2'b11;
        t[3] = 2'b01;
        return t[v];
    endfunction

    // Caller has raised st[d] at a negedge; next posedge is E0.
    task automatic sweep(input int d, input int s, input bit hold,
                         input int pulse_at, input logic [3:0] emask,
                         input logic [27:0] eres, input logic epass);
        int len;
        len = 4 * (s + 1);
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            if (n == 0 && !hold) st[d] = 1'b0;
            if (n == pulse_at) st[d] = 1'b1;
            if (n == pulse_at + 1) st[d] = 1'b0;
            chk($sformatf("busy d%0d n%0d", d, n), 32'(busy_w[d]), 32'd1);
            chk($sformatf("done d%0d n%0d", d, n), 32'(done_w[d]), 32'd0);
            chk($sformatf("ab d%0d n%0d", d, n),
                32'({a_o[d], b_o[d]}), 32'(ab_of(n / (s + 1))));
            if (n == 0) begin
                chk($sformatf("clr_res d%0d", d), 32'(res_w[d]), 32'd0);
                chk($sformatf("clr_mask d%0d", d), 32'(mask_w[d]), 32'd0);
                chk($sformatf("clr_pass d%0d", d), 32'(pass_w[d]), 32'd0);
            end
        end
        @(negedge clk);
        chk($sformatf("fin_done d%0d", d), 32'(done_w[d]), 32'd1);
        chk($sformatf("fin_busy d%0d", d), 32'(busy_w[d]), 32'd0);
        chk($sformatf("fin_pass d%0d", d), 32'(pass_w[d]), 32'(epass));
        chk($sformatf("fin_mask d%0d", d), 32'(mask_w[d]), 32'(emask));
        chk($sformatf("fin_res d%0d", d), 32'(res_w[d]), 32'(eres));
    endtask

    task automatic post_idle(input int d, input logic [3:0] emask,
                             input logic [27:0] eres, input logic epass);
        @(negedge clk);
        chk($sformatf("idle_done d%0d", d), 32'(done_w[d]), 32'd0);
        chk($sformatf("idle_busy d%0d", d), 32'(busy_w[d]), 32'd0);
        chk($sformatf("hold_ab d%0d", d), 32'({a_o[d], b_o[d]}), 32'd1);
        chk($sformatf("hold_pass d%0d", d), 32'(pass_w[d]), 32'(epass));
        chk($sformatf("hold_mask d%0d", d), 32'(mask_w[d]), 32'(emask));
        chk($sformatf("hold_res d%0d", d), 32'(res_w[d]), 32'(eres));
    endtask

    task automatic all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s outs d%0d", tag, d),
                32'({a_o[d], b_o[d], busy_w[d], done_w[d], pass_w[d],
                     mask_w[d]}), 32'd0);
            chk($sformatf("%s res d%0d", tag, d), 32'(res_w[d]), 32'd0);
        end
    endtask

    task automatic quiet(input int cyc);
        int seen;
        seen = 0;
        for (int n = 0; n < cyc; n++) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) seen++;
        end
        chk("quiet d0", 32'(seen), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        xor_fault = 3'b000;
        for (int d = 0; d < 3; d++) st[d] = 1'b0;

        #2 rst = 1'b1;
        #1 all_zero("por");
        @(negedge clk);
        rst = 1'b0;
        quiet(20);

        st[0] = 1'b1;
        sweep(0, 2, 1'b0, -10, 4'b0000, GOLD, 1'b1);
        post_idle(0, 4'b0000, GOLD, 1'b1);

        xor_fault[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b1;
        sweep(0, 2, 1'b0, -10, 4'b1010, FAULT, 1'b0);
        post_idle(0, 4'b1010, FAULT, 1'b0);
        xor_fault[0] = 1'b0;

        @(negedge clk);
        st[0] = 1'b1;
        sweep(0, 2, 1'b1, -10, 4'b0000, GOLD, 1'b1);
        sweep(0, 2, 1'b0, -10, 4'b0000, GOLD, 1'b1);
        post_idle(0, 4'b0000, GOLD, 1'b1);

        @(negedge clk);
        st[0] = 1'b1;
        sweep(0, 2, 1'b0, 5, 4'b0000, GOLD, 1'b1);
        post_idle(0, 4'b0000, GOLD, 1'b1);

        @(negedge clk);
        st[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            st[0] = 1'b0;
        end
        chk("pre_rst a", 32'(a_o[0]), 32'd1);
        chk("pre_rst res", 32'(res_w[0]), 32'h1D);
        #2 rst = 1'b1;
        #1 all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        quiet(6);
        st[0] = 1'b1;
        sweep(0, 2, 1'b0, -10, 4'b0000, GOLD, 1'b1);
        post_idle(0, 4'b0000, GOLD, 1'b1);

        @(negedge clk);
        st[1] = 1'b1;
        sweep(1, 0, 1'b0, -10, 4'b0000, GOLD, 1'b1);
        post_idle(1, 4'b0000, GOLD, 1'b1);

        @(negedge clk);
        st[2] = 1'b1;
        sweep(2, 15, 1'b0, -10, 4'b0000, GOLD, 1'b1);
        post_idle(2, 4'b0000, GOLD, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
